// File: rtl/mouse_init_seq.sv
// PS/2 mouse initialisation sequencer: resets the mouse, programs the sample rate, enables
// streaming, then forwards each received byte while in READY.
module mouse_init_seq #(
  parameter int unsigned INHIBIT_CYC = 2500,
  parameter int unsigned TIMEOUT_CYC = 500000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        msclk,
  inout  wire        msdat,
  input  logic       start,
  input  logic [7:0] rate,
  output logic       busy,
  output logic       ready,
  output logic       err,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  localparam int unsigned CntMax = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);

  typedef enum logic [3:0] {
    StIdle, StInhibit, StTx, StTxAck, StWaitRsp, StWaitBat, StWaitId, StReady, StErr
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        clk_sync_q, dat_sync_q;
  logic              clk_prev_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [10:0]       tx_shift_q, tx_shift_d;
  logic [9:0]        rx_shift_q, rx_shift_d;
  logic [1:0]        cmd_idx_q, cmd_idx_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [7:0]        rate_q, rate_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;

  logic        fall, dat_s, rx_state, rx_done, rx_good, timeout, fail, ack, enter;
  logic        clk_oe, dat_oe;
  logic [10:0] rx_frame;
  logic [7:0]  rx_byte, cmd_byte;

  assign fall     = clk_prev_q & ~clk_sync_q[1];
  assign dat_s    = dat_sync_q[1];
  assign rx_state = state_q inside {StWaitRsp, StWaitBat, StWaitId, StReady};
  assign rx_frame = {dat_s, rx_shift_q};
  assign rx_byte  = rx_frame[8:1];
  assign rx_done  = fall && rx_state && (bit_cnt_q == 4'd10);
  assign rx_good  = rx_done && !rx_frame[0] && rx_frame[10] && (^rx_frame[9:1]);
  assign timeout  = (cnt_q == CntW'(TIMEOUT_CYC - 1));
  assign enter    = (state_d != state_q);

  always_comb begin
    unique case (cmd_idx_q)
      2'd0:    cmd_byte = 8'hFF;
      2'd1:    cmd_byte = 8'hF3;
      2'd2:    cmd_byte = rate_q;
      default: cmd_byte = 8'hF4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      tx_shift_q <= '1;
      rx_shift_q <= '0;
      cmd_idx_q  <= '0;
      retry_q    <= '0;
      rate_q     <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_sync_q <= {clk_sync_q[0], msclk};
      dat_sync_q <= {dat_sync_q[0], msdat};
      clk_prev_q <= clk_sync_q[1];
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      cmd_idx_q  <= cmd_idx_d;
      retry_q    <= retry_d;
      rate_q     <= rate_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_idx_d = cmd_idx_q;
    retry_d   = retry_q;
    rate_d    = rate_q;
    fail      = 1'b0;
    ack       = 1'b0;
    unique case (state_q)
      StIdle, StReady, StErr: begin
        if (start) begin
          state_d   = StInhibit;
          cmd_idx_d = 2'd0;
          retry_d   = '0;
          rate_d    = rate;
        end
      end
      StInhibit: if (cnt_q == CntW'(INHIBIT_CYC - 1)) state_d = StTx;
      StTx:      if (fall && bit_cnt_q == 4'd9) state_d = StTxAck;
      StTxAck: begin
        if (fall) begin
          if (!dat_s) state_d = StWaitRsp;
          else        fail    = 1'b1;
        end
      end
      StWaitRsp: begin
        if (rx_done) begin
          if (rx_good && rx_byte == 8'hFA) begin
            ack = 1'b1;
            unique case (cmd_idx_q)
              2'd0: state_d = StWaitBat;
              2'd3: state_d = StReady;
              default: begin
                cmd_idx_d = cmd_idx_q + 2'd1;
                state_d   = StInhibit;
              end
            endcase
          end else begin
            fail = 1'b1;
          end
        end
      end
      StWaitBat: begin
        if (rx_done) begin
          if (rx_good && rx_byte == 8'hAA) state_d = StWaitId;
          else                             fail    = 1'b1;
        end
      end
      StWaitId: begin
        if (rx_done) begin
          if (rx_good && rx_byte == 8'h00) begin
            cmd_idx_d = 2'd1;
            state_d   = StInhibit;
          end else begin
            fail = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // A silent device after reset is not worth retrying.
    if (timeout && busy) begin
      if (state_q == StWaitBat) begin
        fail    = 1'b0;
        state_d = StErr;
      end else begin
        fail = 1'b1;
      end
    end
    if (fail) begin
      cmd_idx_d = cmd_idx_q;
      if (retry_q == RetryW'(MAX_RETRY - 1)) begin
        state_d = StErr;
      end else begin
        retry_d = retry_q + RetryW'(1);
        state_d = StInhibit;
      end
    end else if (ack) begin
      retry_d = '0;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    // Our own inhibit pulls msclk low; that edge must not stretch the inhibit time.
    if (enter || (fall && state_q != StInhibit)) begin
      cnt_d = '0;
    end else if (cnt_q != CntW'(CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
    if (enter) begin
      bit_cnt_d = '0;
    end else if (fall && (state_q == StTx || rx_state)) begin
      bit_cnt_d = rx_done ? 4'd0 : bit_cnt_q + 4'd1;
    end else if (state_q == StReady && timeout) begin
      bit_cnt_d = '0;
    end
    if (state_q == StInhibit) begin
      tx_shift_d = {1'b1, ~^cmd_byte, cmd_byte, 1'b0};
    end else if (state_q == StTx && fall) begin
      tx_shift_d = {1'b1, tx_shift_q[10:1]};
    end
    if (fall && rx_state) rx_shift_d = {dat_s, rx_shift_q[9:1]};
    if (rx_good) rx_data_d = rx_byte;
    rx_valid_d = rx_good && (state_q == StReady);
  end

  always_comb begin
    clk_oe = (state_q == StInhibit);
    dat_oe = (state_q == StTx) && !tx_shift_q[0];
    busy   = !(state_q inside {StIdle, StReady, StErr});
    ready  = (state_q == StReady);
    err    = (state_q == StErr);
  end

  assign msclk    = clk_oe ? 1'b0 : 1'bz;
  assign msdat    = dat_oe ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_mouse_init_seq.sv
// Directed bench for mouse_init_seq with a behavioural PS/2 mouse on the bus.
module tb_mouse_init_seq;

  localparam int unsigned InhCyc    = 20;
  localparam int unsigned ToCyc     = 300;
  localparam int unsigned H         = 6;
  localparam int unsigned ReqBudget = 2000;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] rate;
  wire        msclk, msdat;
  logic       dev_clk_low, dev_dat_low;
  logic       busy, ready, err, rx_valid;
  logic [7:0] rx_data;

  int n_checks = 0;
  int n_errors = 0;
  int last_inh = 0;
  int n_strobe = 0;
  logic [7:0] strobe_log [8];

  assign msclk = dev_clk_low ? 1'b0 : 1'bz;
  assign msdat = dev_dat_low ? 1'b0 : 1'bz;
  pullup (msclk);
  pullup (msdat);

  mouse_init_seq #(
    .INHIBIT_CYC(InhCyc),
    .TIMEOUT_CYC(ToCyc),
    .MAX_RETRY  (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .msclk   (msclk),
    .msdat   (msdat),
    .start   (start),
    .rate    (rate),
    .busy    (busy),
    .ready   (ready),
    .err     (err),
    .rx_data (rx_data),
    .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      if (n_strobe < 8) strobe_log[n_strobe] <= rx_data;
      n_strobe <= n_strobe + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic dev_pulse();
    dev_clk_low = 1'b1; repeat (H) @(negedge clk);
    dev_clk_low = 1'b0; repeat (H) @(negedge clk);
  endtask

  // Returns at the first cycle after the host releases msclk.
  task automatic wait_req(output bit ok, output int inh_len);
    int n;
    n = 0;
    inh_len = 0;
    while (msclk !== 1'b0 && n < ReqBudget) begin @(negedge clk); n++; end
    while (msclk === 1'b0 && inh_len < ReqBudget) begin @(negedge clk); inh_len++; end
    ok = (msclk === 1'b1) && (msdat === 1'b0);
  endtask

  // Result word: {request seen, stop=1, odd parity ok, byte}.
  task automatic dev_recv(output logic [10:0] word);
    bit ok;
    int len;
    logic [9:0] bits;
    bits = '0;
    wait_req(ok, len);
    last_inh = len;
    if (ok) begin
      repeat (H) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        dev_clk_low = 1'b1; repeat (H) @(negedge clk);
        bits[i] = msdat;
        dev_clk_low = 1'b0; repeat (H) @(negedge clk);
      end
      dev_dat_low = 1'b1; repeat (2) @(negedge clk);
      dev_pulse();
      dev_dat_low = 1'b0;
    end
    word = {ok, bits[9], ^bits[8:0], bits[7:0]};
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] exp);
    logic [10:0] w;
    dev_recv(w);
    check_eq(tag, {5'd0, w}, {5'd0, 3'b111, exp});
  endtask

  task automatic dev_send(input logic [7:0] b, input bit bad_par);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      dev_dat_low = ~f[i];
      repeat (2) @(negedge clk);
      dev_pulse();
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic init_to_f4(input logic [7:0] r);
    expect_tx("tx_ff", 8'hFF);
    dev_send(8'hFA, 1'b0);
    dev_send(8'hAA, 1'b0);
    dev_send(8'h00, 1'b0);
    expect_tx("tx_f3", 8'hF3);
    dev_send(8'hFA, 1'b0);
    expect_tx("tx_rate", r);
    dev_send(8'hFA, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int len, t, n_req, base, nlow;
    rst = 1'b1; start = 1'b0; rate = 8'h00; dev_clk_low = 1'b0; dev_dat_low = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 16'(busy), 16'd0);
    check_eq("rst_ready", 16'(ready), 16'd0);
    check_eq("rst_err", 16'(err), 16'd0);
    check_eq("rst_rx_valid", 16'(rx_valid), 16'd0);
    check_eq("rst_rx_data", 16'(rx_data), 16'h00);
    check_eq("rst_msclk", 16'(msclk), 16'd1);
    check_eq("rst_msdat", 16'(msdat), 16'd1);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check_eq("idle_busy", 16'(busy), 16'd0);
    check_eq("no_auto_init", 16'(msclk), 16'd1);

    // Happy path
    rate = 8'h64;
    pulse_start();
    check_eq("busy_start", 16'(busy), 16'd1);
    expect_tx("tx_ff", 8'hFF);
    check_eq("inhibit_len", 16'(last_inh), 16'(InhCyc));
    dev_send(8'hFA, 1'b0);
    dev_send(8'hAA, 1'b0);
    dev_send(8'h00, 1'b0);
    expect_tx("tx_f3", 8'hF3);
    dev_send(8'hFA, 1'b0);
    expect_tx("tx_rate", 8'h64);
    dev_send(8'hFA, 1'b0);
    expect_tx("tx_f4", 8'hF4);
    dev_send(8'hFA, 1'b0);
    repeat (10) @(negedge clk);
    check_eq("happy_ready", 16'(ready), 16'd1);
    check_eq("happy_busy", 16'(busy), 16'd0);
    check_eq("happy_err", 16'(err), 16'd0);
    check_eq("no_strobe_init", 16'(n_strobe), 16'd0);

    // Streaming in READY, one frame with bad parity
    base = n_strobe;
    dev_send(8'h08, 1'b0);
    dev_send(8'h05, 1'b0);
    dev_send(8'h33, 1'b1);
    dev_send(8'hFB, 1'b0);
    repeat (5) @(negedge clk);
    check_eq("stream_count", 16'(n_strobe - base), 16'd3);
    check_eq("stream_b0", 16'(strobe_log[0]), 16'h08);
    check_eq("stream_b1", 16'(strobe_log[1]), 16'h05);
    check_eq("stream_b2", 16'(strobe_log[2]), 16'hFB);
    check_eq("stream_rx_data", 16'(rx_data), 16'hFB);
    check_eq("stream_ready", 16'(ready), 16'd1);

    // Resend: FE on F3 once, FE on F4 twice (needs retry reset after each ACK)
    rate = 8'h50;
    pulse_start();
    expect_tx("rs_ff", 8'hFF);
    dev_send(8'hFA, 1'b0);
    dev_send(8'hAA, 1'b0);
    dev_send(8'h00, 1'b0);
    expect_tx("rs_f3_a", 8'hF3);
    dev_send(8'hFE, 1'b0);
    expect_tx("rs_f3_b", 8'hF3);
    dev_send(8'hFA, 1'b0);
    expect_tx("rs_rate", 8'h50);
    dev_send(8'hFA, 1'b0);
    for (int k = 0; k < 2; k++) begin
      expect_tx("rs_f4_nak", 8'hF4);
      dev_send(8'hFE, 1'b0);
    end
    expect_tx("rs_f4_ack", 8'hF4);
    dev_send(8'hFA, 1'b0);
    repeat (10) @(negedge clk);
    check_eq("rs_ready", 16'(ready), 16'd1);
    check_eq("rs_err", 16'(err), 16'd0);

    // Retry exhaustion on F4
    rate = 8'h28;
    pulse_start();
    init_to_f4(8'h28);
    for (int k = 0; k < 3; k++) begin
      expect_tx("ex_f4", 8'hF4);
      dev_send(8'hFE, 1'b0);
    end
    repeat (10) @(negedge clk);
    check_eq("ex_err", 16'(err), 16'd1);
    check_eq("ex_ready", 16'(ready), 16'd0);
    check_eq("ex_busy", 16'(busy), 16'd0);
    check_eq("ex_msclk", 16'(msclk), 16'd1);
    check_eq("ex_msdat", 16'(msdat), 16'd1);
    nlow = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (msclk === 1'b0) nlow++;
    end
    check_eq("ex_no_4th_send", 16'(nlow), 16'd0);

    // Timeout: device never clocks
    pulse_start();
    check_eq("to_restart_busy", 16'(busy), 16'd1);
    check_eq("to_restart_inhibit", 16'(msclk), 16'd0);
    n_req = 0;
    for (int k = 0; k < 3; k++) begin
      wait_req(ok, len);
      if (ok) n_req++;
    end
    t = 0;
    while (!err && t < ReqBudget) begin @(negedge clk); t++; end
    check_eq("to_sends", 16'(n_req), 16'd3);
    check_eq("to_len", 16'(t), 16'(ToCyc));
    check_eq("to_err", 16'(err), 16'd1);

    // Restart from ERR, then reset during the 5th falling edge of FF
    pulse_start();
    check_eq("err_restart_busy", 16'(busy), 16'd1);
    check_eq("err_restart_inhibit", 16'(msclk), 16'd0);
    wait_req(ok, len);
    check_eq("mid_req", 16'(ok), 16'd1);
    repeat (H) @(negedge clk);
    for (int k = 0; k < 4; k++) dev_pulse();
    dev_clk_low = 1'b1;
    repeat (4) @(negedge clk);
    dev_clk_low = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_busy", 16'(busy), 16'd0);
    check_eq("mid_ready", 16'(ready), 16'd0);
    check_eq("mid_err", 16'(err), 16'd0);
    check_eq("mid_rx_valid", 16'(rx_valid), 16'd0);
    check_eq("mid_rx_data", 16'(rx_data), 16'h00);
    check_eq("mid_msclk", 16'(msclk), 16'd1);
    check_eq("mid_msdat", 16'(msdat), 16'd1);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check_eq("post_rst_idle", 16'(busy), 16'd0);
    check_eq("post_rst_msclk", 16'(msclk), 16'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mouse_init_seq.md
MOUSE_INIT_SEQ -- requirements
Module: mouse_init_seq

Parameters
REQ-001 SHALL have parameter INHIBIT_CYC, default 2500: clk cycles msclk is held low before a host transmit (100 us at 25 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 500000: clk cycles allowed for any awaited device event (20 ms at 25 MHz).
REQ-003 SHALL have parameter MAX_RETRY, default 3: resend attempts per command before error.

Interface
REQ-004 SHALL have port clk, input, 1: sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous reset, active-high.
REQ-006 SHALL have port msclk, inout, 1: PS/2 clock, open-drain (drive 0 or release to z).
REQ-007 SHALL have port msdat, inout, 1: PS/2 data, open-drain.
REQ-008 SHALL have port start, input, 1: one-cycle pulse to begin the init sequence; honoured only in IDLE, READY or ERR.
REQ-009 SHALL have port rate, input, 8: sample-rate argument, captured on accepted start.
REQ-010 SHALL have port busy, output, 1: high in every state except IDLE, READY and ERR.
REQ-011 SHALL have port ready, output, 1: high only in READY.
REQ-012 SHALL have port err, output, 1: high only in ERR.
REQ-013 SHALL have port rx_data, output, 8: last received device byte.
REQ-014 SHALL have port rx_valid, output, 1: one-cycle strobe, asserted only in READY, when a parity-good byte completes.

Function
REQ-015 SHALL synchronise msclk through two flops; a device clock event is a 1-to-0 transition of the synchronised value.
REQ-016 SHALL send the command list FF; F3, rate; F4, in that order, each byte as a host-to-device frame.
REQ-017 SHALL form each transmit frame as follows: msclk low for INHIBIT_CYC cycles; msdat low (start); release msclk; on each following falling edge present d0..d7, then odd parity, then release msdat (stop); on the 11th falling edge sample msdat, where 0 = line ACK.
REQ-018 SHALL receive device frames as 11 bits sampled on falling edges (start 0, d0..d7, odd parity, stop 1); frame complete on 11th bit; bad parity or bad start/stop = frame error.
REQ-019 SHALL use states IDLE, INHIBIT, TX, TXACK, WAITRSP, WAITBAT, WAITID, READY, ERR.
REQ-020 SHALL use these transitions:
- IDLE/READY/ERR, on start -> INHIBIT.
- INHIBIT, after INHIBIT_CYC -> TX.
- TX, after 10th edge -> TXACK.
- TXACK, on 11th edge -> WAITRSP; missing line ACK is a failure.
- WAITRSP: FA after FF -> WAITBAT; FA after other bytes -> next byte via INHIBIT, or READY after F4; FE or frame error -> failure.
- WAITBAT: AA -> WAITID; any other byte -> failure.
- WAITID: 00 -> INHIBIT for F3; any other byte -> failure.
REQ-021 SHALL, on failure, increment the retry count and resend the current byte; when the count reaches MAX_RETRY it SHALL go to ERR instead.
REQ-022 SHALL reset the retry count whenever a byte is acknowledged.
REQ-023 SHALL reset the timeout counter on every state entry and every falling edge; expiry in any busy state is a failure, except in WAITBAT, where expiry goes directly to ERR.
REQ-024 SHALL release msclk and msdat in every state except INHIBIT and TX.
REQ-025 SHALL let a start pulse during a busy state be ignored; the sequence is not restarted.
REQ-026 SHALL, in READY, pass each good frame to rx_data with rx_valid; frame errors in READY are dropped silently.

Reset
REQ-027 SHALL, while rst=1, force state IDLE, release both lines, clear counters, retry count, bit counter and shift register, and hold busy=ready=err=rx_valid=0 and rx_data=00.
REQ-028 SHALL let rst asserted mid-frame abort the frame and release the lines on the next clk edge.
REQ-029 SHALL keep the block in IDLE after reset until start; no automatic init.

Verification
REQ-030 Happy path: start with rate=64, device model ACKs all bytes and returns AA,00 after FF -> bytes FF,F3,64,F4 sent with correct odd parity, then ready=1, busy=0.
REQ-031 Resend: device answers FE to the first F3, then FA -> F3 sent twice, sequence completes, err=0.
REQ-032 Retry exhaustion: device answers FE to every F4 -> F4 sent 3 times, then err=1, ready=0, lines released.
REQ-033 Stream: in READY, device sends 08,05,FB -> three rx_valid strobes with rx_data 08,05,FB; a frame with bad parity produces no strobe.
REQ-034 Timeout: device never clocks after the INHIBIT of FF -> failure after TIMEOUT_CYC, three sends, then ERR; start from ERR restarts at INHIBIT.
REQ-035 Reset mid-TX: rst at the 5th falling edge of FF -> next cycle IDLE, msclk=msdat=z, all outputs 0.
